// File: rtl/pll_drp_reconfig.sv
// DRP reconfiguration engine for a PLLE2-class PLL: DIVCLK, CLKFBOUT mult, CLKOUT0 divide.
// Optional lock watchdog: define PLL_DRP_LOCK_TIMEOUT_EN.
module pll_drp_reconfig #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_divclk,
  input  logic [5:0]  req_mult,
  input  logic [5:0]  req_out0_div,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [6:0]  drp_daddr,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic        pll_rst,
  input  logic        pll_locked
);

  typedef enum logic [2:0] {
    IDLE, ASSERT_RST, RD, RD_WAIT, WR, WR_WAIT, RELEASE, WAIT_LOCK
  } state_t;

  localparam logic [16:0] HOLD_LAST = 17'(RST_CYCLES - 1);

  if (RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > 131071) begin : g_bad_param
    $error("pll_drp_reconfig: RST_CYCLES/LOCK_TIMEOUT out of range");
  end

  state_t      state, state_n;
  logic [5:0]  divclk_q, mult_q, out0_q;
  logic [2:0]  idx;
  logic [15:0] wdata;
  logic [16:0] hold_cnt;
  logic        lk_first;
  logic        req_ok, done_n, err_n;
  logic [6:0]  addr;
  logic [15:0] keep, newb;

  // {high[11:6], low[5:0]} counter encoding for a divide value
  function automatic logic [11:0] hl(input logic [5:0] d);
    logic [5:0] h;
    h = {1'b0, d[5:1]};
    return {h, d - h};
  endfunction

  assign req_ok = (req_divclk != 6'd0) && (req_mult > 6'd1) && (req_out0_div != 6'd0);

  always_comb begin
    addr = 7'h00;
    keep = 16'h0000;
    newb = 16'h0000;
    case (idx)
      3'd0: begin addr = 7'h08; keep = 16'h1000; newb = {4'h0, hl(out0_q)}; end
      3'd1: begin addr = 7'h09; keep = 16'hFC00; newb = {8'h00, out0_q[0], out0_q == 6'd1, 6'h00}; end
      3'd2: begin addr = 7'h14; keep = 16'h1000; newb = {4'h0, hl(mult_q)}; end
      3'd3: begin addr = 7'h15; keep = 16'hFC00; newb = {8'h00, mult_q[0], mult_q == 6'd1, 6'h00}; end
      3'd4: begin addr = 7'h16; keep = 16'hC000; newb = {2'b00, divclk_q[0], divclk_q == 6'd1, hl(divclk_q)}; end
      default: ;
    endcase
  end

`ifdef PLL_DRP_LOCK_TIMEOUT_EN
  localparam logic [16:0] TO_LAST = 17'(LOCK_TIMEOUT - 1);
  logic [16:0] lock_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) lock_cnt <= '0;
    else         lock_cnt <= (state == WAIT_LOCK) ? lock_cnt + 17'd1 : '0;
  end
`endif

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE:
        if (req_valid && req_ready) begin
          if (req_ok) state_n = ASSERT_RST;
          else        err_n   = 1'b1;
        end
      ASSERT_RST: state_n = RD;
      RD:         state_n = RD_WAIT;
      RD_WAIT:    if (drp_drdy) state_n = WR;
      WR:         state_n = WR_WAIT;
      WR_WAIT:    if (drp_drdy) state_n = (idx == 3'd4) ? RELEASE : RD;
      RELEASE:    if (hold_cnt >= HOLD_LAST) state_n = WAIT_LOCK;
      WAIT_LOCK:
        // LOCKED is meaningless in the first cycle after reset release
        if (!lk_first && pll_locked) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
`ifdef PLL_DRP_LOCK_TIMEOUT_EN
        else if (lock_cnt == TO_LAST) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      divclk_q  <= '0;
      mult_q    <= '0;
      out0_q    <= '0;
      idx       <= '0;
      wdata     <= '0;
      hold_cnt  <= '0;
      lk_first  <= 1'b1;
    end else begin
      state     <= state_n;
      req_ready <= (state_n == IDLE);
      done      <= done_n;
      err       <= err_n;
      lk_first  <= (state != WAIT_LOCK);
      if (state == IDLE && req_valid && req_ready) begin
        divclk_q <= req_divclk;
        mult_q   <= req_mult;
        out0_q   <= req_out0_div;
      end
      if (state == IDLE)                   idx <= '0;
      else if (state == WR_WAIT && drp_drdy) idx <= idx + 3'd1;
      if (state == RD_WAIT && drp_drdy) wdata <= (drp_do & keep) | newb;
      // hold counter is zero in the first ASSERT_RST cycle and saturates
      if (state == IDLE)         hold_cnt <= '0;
      else if (hold_cnt != '1)   hold_cnt <= hold_cnt + 17'd1;
    end
  end

  assign busy      = (state != IDLE);
  assign pll_rst   = (state inside {ASSERT_RST, RD, RD_WAIT, WR, WR_WAIT, RELEASE});
  assign drp_den   = (state == RD) || (state == WR);
  assign drp_dwe   = (state == WR);
  assign drp_daddr = drp_den ? addr : 7'h00;
  assign drp_di    = drp_dwe ? wdata : 16'h0000;

endmodule

// File: tb/tb_pll_drp_reconfig.sv
// Bench for pll_drp_reconfig: DRP slave + PLL lock model, write log checked against a rule-level model.
module tb_pll_drp_reconfig;
  localparam int RSTC = 64;
  localparam int LTO  = 100;
  localparam logic [6:0] ADDR [5] = '{7'h08, 7'h09, 7'h14, 7'h15, 7'h16};

  logic        clk = 1'b0, resetn = 1'b0, req_valid = 1'b0;
  logic [5:0]  req_divclk = '0, req_mult = '0, req_out0_div = '0;
  logic        req_ready, busy, done, err, drp_den, drp_dwe, pll_rst;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di;
  logic [15:0] drp_do = '0;
  logic        drp_drdy = 1'b0, pll_locked = 1'b0;

  always #5 clk = ~clk;

  pll_drp_reconfig #(.RST_CYCLES(RSTC), .LOCK_TIMEOUT(LTO)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_divclk(req_divclk), .req_mult(req_mult), .req_out0_div(req_out0_div),
    .busy(busy), .done(done), .err(err), .drp_den(drp_den), .drp_dwe(drp_dwe),
    .drp_daddr(drp_daddr), .drp_di(drp_di), .drp_do(drp_do), .drp_drdy(drp_drdy),
    .pll_rst(pll_rst), .pll_locked(pll_locked)
  );

  int tests = 0, fails = 0, cyc = 0;
  logic [15:0] mem [0:127];
  logic [22:0] wq [$];
  int drp_lat = 1, lock_dly = -1, lk_left = -1, left = 0;
  bit force_lock = 1'b0, pend = 1'b0, pwe = 1'b0;
  logic [6:0]  paddr = '0;
  logic [15:0] pdata = '0;
  logic        prev_rst = 1'b0;
  int rise_cyc = 0, fall_cyc = 0, done_cyc = 0, err_cyc = 0;
  int done_cnt = 0, err_cnt = 0, den_cnt = 0, rise_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // DRP slave, PLL lock model and event monitor; drives/samples on the falling edge
  always @(negedge clk) begin
    drp_drdy = 1'b0;
    drp_do   = 16'($urandom);
    if (!resetn) pend = 1'b0;
    else if (pend) begin
      left--;
      if (left == 0) begin
        drp_drdy = 1'b1;
        drp_do   = mem[paddr];
        if (pwe) mem[paddr] = pdata;
        pend = 1'b0;
      end
    end
    if (drp_den) begin
      if (pend) chk("den_overlap", 1, 0);
      pend = 1'b1; left = drp_lat; paddr = drp_daddr; pwe = drp_dwe; pdata = drp_di;
      den_cnt++;
      if (drp_dwe) begin
        wq.push_back({drp_daddr, drp_di});
        chk("rst_during_wr", pll_rst, 1);
      end
    end
    if (pll_rst) begin
      pll_locked = 1'b0;
      lk_left    = -1;
      if (!prev_rst) begin rise_cyc = cyc; rise_cnt++; end
    end else begin
      if (prev_rst) begin fall_cyc = cyc; lk_left = lock_dly; end
      if (force_lock || lk_left == 0) begin pll_locked = 1'b1; lk_left = -1; end
      else if (lk_left > 0) lk_left--;
    end
    prev_rst = pll_rst;
    if (done) begin done_cnt++; done_cyc = cyc; chk("busy_at_done", busy, 0); end
    if (err)  begin err_cnt++;  err_cyc  = cyc; end
  end

  // reference: divide D -> high=floor(D/2), low=D-high, edge=D odd, nocnt=(D==1)
  function automatic logic [15:0] hl(input int d);
    return 16'((d / 2) * 64 + (d - d / 2));
  endfunction

  function automatic logic [15:0] exp_wr(input int i, input int dv, input int ml, input int o0,
                                         input logic [15:0] old);
    case (i)
      0: return (old & 16'h1000) | hl(o0);
      1: return (old & 16'hFC00) | 16'((o0 % 2) * 128 + (o0 == 1 ? 64 : 0));
      2: return (old & 16'h1000) | hl(ml);
      3: return (old & 16'hFC00) | 16'((ml % 2) * 128 + (ml == 1 ? 64 : 0));
      default: return (old & 16'hC000) | 16'((dv % 2) * 8192 + (dv == 1 ? 4096 : 0)) | hl(dv);
    endcase
  endfunction

  task automatic issue(input int dv, input int ml, input int o0);
    int n;
    for (n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (req_ready) break;
    end
    if (n == 20) chk("ready_timeout", 0, 1);
    req_divclk = 6'(dv); req_mult = 6'(ml); req_out0_div = 6'(o0); req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_divclk = 6'($urandom); req_mult = 6'($urandom); req_out0_div = 6'($urandom);
  endtask

  task automatic run_legal(input int dv, input int ml, input int o0, input int lat, input int k);
    logic [15:0] old [5];
    int d0, e0, n;
    for (int i = 0; i < 5; i++) old[i] = mem[ADDR[i]];
    drp_lat = lat; lock_dly = k; wq.delete();
    d0 = done_cnt; e0 = err_cnt;
    issue(dv, ml, o0);
    chk("busy_after_accept", busy, 1);
    chk("rst_after_accept", pll_rst, 1);
    for (n = 0; n < 3000; n++) begin
      if (done_cnt != d0) break;
      @(posedge clk);
    end
    if (done_cnt == d0) chk("done_timeout", 0, 1);
    #1;
    chk("n_writes", wq.size(), 5);
    for (int i = 0; i < 5 && i < wq.size(); i++) begin
      chk("wr_addr", wq[i][22:16], ADDR[i]);
      chk("wr_data", wq[i][15:0], exp_wr(i, dv, ml, o0, old[i]));
    end
    chk("rst_hold", fall_cyc - rise_cyc, RSTC);
    chk("lock_to_done", done_cyc - fall_cyc, (k < 1 ? 1 : k) + 1);
    chk("no_err", err_cnt, e0);
    chk("done_width", done, 0);
    chk("ready_after_done", req_ready, 1);
    lock_dly = -1;
  endtask

  task automatic run_illegal(input int dv, input int ml, input int o0);
    int dn0, r0;
    dn0 = den_cnt; r0 = rise_cnt;
    issue(dv, ml, o0);
    chk("ill_err", err, 1);
    chk("ill_busy", busy, 0);
    @(posedge clk); #1;
    chk("ill_err_width", err, 0);
    chk("ill_ready", req_ready, 1);
    chk("ill_no_den", den_cnt, dn0);
    chk("ill_no_rst", rise_cnt, r0);
  endtask

  initial begin
    int d0, e0, n;
    for (int a = 0; a < 128; a++) mem[a] = 16'($urandom);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {req_ready, busy, done, err, drp_den, drp_dwe, pll_rst}, 0);
    chk("reset_addr_data", {drp_daddr, drp_di}, 0);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", req_ready, 1);

    for (int i = 0; i < 5; i++) mem[ADDR[i]] = 16'hFFFF;
    run_legal(1, 10, 5, 2, 10);
    for (int i = 0; i < 5; i++) mem[ADDR[i]] = 16'h0000;
    run_legal(1, 10, 5, 2, 10);
    run_legal(1, 10, 5, 1, 0);
    run_legal(63, 63, 63, 1, 1);
    run_legal(2, 2, 1, 3, 3);

    run_illegal(5, 1, 5);
    run_illegal(0, 10, 5);
    run_illegal(5, 0, 5);
    run_illegal(5, 10, 0);

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 5; i++) mem[ADDR[i]] = 16'($urandom);
      run_legal($urandom_range(1, 63), $urandom_range(2, 63), $urandom_range(1, 63),
                $urandom_range(1, 3), $urandom_range(0, 12));
    end

    // abort during the third write's wait for drdy
    drp_lat = 2; lock_dly = -1; wq.delete(); d0 = done_cnt;
    issue(1, 10, 5);
    for (n = 0; n < 500; n++) begin
      @(posedge clk);
      if (wq.size() == 3) break;
    end
    #1;
    chk("abort_reached_wr3", wq.size(), 3);
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("abort_rst", pll_rst, 0);
    chk("abort_den", drp_den, 0);
    chk("abort_busy", busy, 0);
    resetn = 1'b1;
    chk("abort_no_done", done_cnt, d0);
    run_legal(7, 20, 3, 2, 4);

    // no lock after release
    drp_lat = 1; lock_dly = -1; d0 = done_cnt; e0 = err_cnt;
    issue(4, 12, 9);
    for (n = 0; n < 500; n++) begin
      @(posedge clk); #1;
      if (!pll_rst) break;
    end
    chk("nolock_released", pll_rst, 0);
    repeat (150) @(posedge clk);
    #1;
`ifdef PLL_DRP_LOCK_TIMEOUT_EN
    chk("to_err_cnt", err_cnt, e0 + 1);
    chk("to_err_time", err_cyc - fall_cyc, LTO);
    chk("to_no_done", done_cnt, d0);
    chk("to_busy", busy, 0);
    chk("to_rst", pll_rst, 0);
`else
    chk("hang_no_err", err_cnt, e0);
    chk("hang_no_done", done_cnt, d0);
    chk("hang_busy", busy, 1);
    force_lock = 1'b1;
    for (n = 0; n < 20; n++) begin
      if (done_cnt != d0) break;
      @(posedge clk);
    end
    chk("late_lock_done", done_cnt, d0 + 1);
    force_lock = 1'b0;
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished (cycle %0d)", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end
endmodule
